// File: rtl/pwm_sample_feeder.sv
// Sample feeder for the PWM modulator: rounds/saturates filter samples to 11-bit
// offset binary, buffers them, and presents one per 2048-clock frame on SigVec.
module pwm_sample_feeder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MID_CODE   = 1024
) (
    input  logic                          Clk_pwm,
    input  logic                          Rst,
    input  logic signed [DATA_W-1:0]      SampleIn,
    input  logic                          SampleValid,
    output logic                          SampleReady,
    output logic [10:0]                   SigVec,
    output logic                          FrameStart,
    output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
    output logic                          Underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int SHIFT = DATA_W - 11;

    typedef logic signed [DATA_W:0] wide_t;

    localparam wide_t            RND_HALF   = wide_t'(1) << (DATA_W - 12);
    localparam wide_t            SAT_HI     = wide_t'(1023);
    localparam wide_t            SAT_LO     = wide_t'(-1024);
    localparam logic [10:0]      FRAME_LAST = 11'd2047;
    localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO   = '0;

    // One extra bit of headroom keeps the half-LSB add from overflowing.
    function automatic wide_t round_q(input logic signed [DATA_W-1:0] x);
        wide_t w;
        w = wide_t'(x) + RND_HALF;
        return w >>> SHIFT;
    endfunction

    function automatic logic signed [10:0] sat_q(input wide_t r);
        logic signed [10:0] s;
        if (r > SAT_HI) begin
            s = 11'sh3FF;
        end else if (r < SAT_LO) begin
            s = 11'sh400;
        end else begin
            s = r[10:0];
        end
        return s;
    endfunction

    logic [10:0]             frame_cnt;
    logic                    frame_end;
    logic                    pop;
    logic                    vld_p0;
    logic signed [10:0]      sat_p0;
    logic [10:0]             code_p0;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [10:0]             mem [FIFO_DEPTH];

    assign SampleReady = (FifoLevel < DEPTH_LVL);
    assign frame_end   = (frame_cnt == FRAME_LAST);
    assign pop         = frame_end && (FifoLevel != LVL_ZERO);

    // Stage p0: conversion happens on the way into the FIFO.
    assign vld_p0  = SampleValid && SampleReady;
    assign sat_p0  = sat_q(round_q(SampleIn));
    assign code_p0 = {~sat_p0[10], sat_p0[9:0]};

    always_ff @(posedge Clk_pwm) begin
        if (vld_p0) begin
            mem[wr_ptr] <= code_p0;
        end
    end

    always_ff @(posedge Clk_pwm) begin
        if (Rst) begin
            frame_cnt  <= '0;
            FrameStart <= 1'b0;
            SigVec     <= 11'(MID_CODE);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FifoLevel  <= '0;
            Underrun   <= 1'b0;
        end else begin
            frame_cnt  <= frame_cnt + 11'd1;
            FrameStart <= frame_end;
            if (vld_p0) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // An empty FIFO at the frame edge holds SigVec; a same-edge push is not bypassed.
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                SigVec <= mem[rd_ptr];
            end
            if (frame_end && (FifoLevel == LVL_ZERO)) begin
                Underrun <= 1'b1;
            end
            case ({vld_p0, pop})
                2'b10:   FifoLevel <= FifoLevel + LVL_W'(1);
                2'b01:   FifoLevel <= FifoLevel - LVL_W'(1);
                default: FifoLevel <= FifoLevel;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed bench for pwm_sample_feeder (DATA_W=16, FIFO_DEPTH=4); expected codes hand-computed.
module tb_pwm_sample_feeder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               sample_ready;
    logic [10:0]        sig_vec;
    logic               frame_start;
    logic [2:0]         fifo_level;
    logic               underrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pwm_sample_feeder #(
        .DATA_W(16),
        .FIFO_DEPTH(4),
        .MID_CODE(1024)
    ) dut (
        .Clk_pwm(clk),
        .Rst(rst),
        .SampleIn(sample_in),
        .SampleValid(sample_valid),
        .SampleReady(sample_ready),
        .SigVec(sig_vec),
        .FrameStart(frame_start),
        .FifoLevel(fifo_level),
        .Underrun(underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // cyc==0 is the first cycle after the last reset edge, so cyc%2048 tracks the frame counter.
    task automatic reset_dut(input int n);
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic push(input logic [15:0] v);
        sample_in = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic run_stable(input int upto, input int exp, input string tag);
        int bad;
        bad = 0;
        while (cyc < upto) begin
            if (sig_vec !== 11'(exp)) bad++;
            tick();
        end
        chk(tag, bad, 0);
    endtask

    logic [15:0] d_vals  [8] = '{16'h0020, 16'h0040, 16'hFFC0, 16'h1000, 16'hF000, 16'h0060, 16'h0080, 16'h00A0};
    int          d_codes [8] = '{1025, 1026, 1022, 1152, 896, 1027, 1028, 1029};

    initial begin
        int fs_bad;
        int sv_bad;
        int ur_bad;
        int idx;
        logic accepted;

        // Idle after reset
        reset_dut(2);
        chk("rst_sigvec", sig_vec, 1024);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_framestart", frame_start, 0);
        chk("rst_underrun", underrun, 0);
        fs_bad = 0; sv_bad = 0; ur_bad = 0;
        while (cyc < 6144) begin
            tick();
            if (frame_start !== ((cyc % 2048) == 0)) fs_bad++;
            if (sig_vec !== 11'd1024) sv_bad++;
            if (underrun !== (cyc >= 2048)) ur_bad++;
            if (cyc == 2048) chk("idle_fs_2048", frame_start, 1);
            if (cyc == 4096) chk("idle_fs_4096", frame_start, 1);
        end
        chk("idle_fs_bad_cycles", fs_bad, 0);
        chk("idle_sigvec_bad_cycles", sv_bad, 0);
        chk("idle_underrun_bad_cycles", ur_bad, 0);

        // Saturation and sign boundaries
        reset_dut(2);
        push(16'h0000);
        push(16'h7FFF);
        push(16'h8000);
        push(16'hFFE0);
        chk("b_level_full", fifo_level, 4);
        chk("b_ready_full", sample_ready, 0);
        run_stable(2048, 1024, "b_frame0_mid");
        chk("b_level_f1", fifo_level, 3);
        run_stable(4096, 1024, "b_code_0000");
        run_stable(6144, 2047, "b_code_7fff");
        run_stable(8192, 0, "b_code_8000");
        chk("b_ur_before_empty", underrun, 0);
        chk("b_level_empty", fifo_level, 0);
        run_stable(10240, 1023, "b_code_ffe0");
        chk("b_ur_after_empty", underrun, 1);
        chk("b_hold_after_empty", sig_vec, 1023);

        // Rounding at half LSB
        reset_dut(2);
        push(16'h000F);
        push(16'h0010);
        run_stable(4096, 1024, "c_code_000f");
        chk("c_half_up", sig_vec, 1025);

        // Continuous valid: back-pressure and ordering
        reset_dut(2);
        idx = 0;
        while (cyc < 10241) begin
            sample_valid = (idx < 8);
            sample_in = (idx < 8) ? d_vals[idx] : 16'h0000;
            accepted = sample_valid && sample_ready;
            tick();
            if (accepted) idx++;
            if (cyc == 10) begin
                chk("d_accepted_initial", idx, 4);
                chk("d_level_full", fifo_level, 4);
                chk("d_ready_full", sample_ready, 0);
            end
            if (cyc == 2047) chk("d_no_accept_when_full", idx, 4);
            if (cyc == 2048) begin
                chk("d_level_after_pop", fifo_level, 3);
                chk("d_ready_after_pop", sample_ready, 1);
                chk("d_code_0", sig_vec, d_codes[0]);
            end
            if (cyc == 2049) begin
                chk("d_one_more_accepted", idx, 5);
                chk("d_level_refull", fifo_level, 4);
                chk("d_ready_refull", sample_ready, 0);
            end
            if (cyc == 4096) chk("d_code_1", sig_vec, d_codes[1]);
            if (cyc == 6144) chk("d_code_2", sig_vec, d_codes[2]);
            if (cyc == 8192) chk("d_code_3", sig_vec, d_codes[3]);
            if (cyc == 10240) begin
                chk("d_code_4", sig_vec, d_codes[4]);
                chk("d_level_end", fifo_level, 3);
                chk("d_underrun_none", underrun, 0);
            end
        end
        sample_valid = 1'b0;

        // Push on the frame-edge cycle with an empty FIFO
        reset_dut(2);
        while (cyc < 2047) tick();
        push(16'h0040);
        chk("e_underrun", underrun, 1);
        chk("e_sigvec_held", sig_vec, 1024);
        chk("e_level", fifo_level, 1);
        run_stable(4096, 1024, "e_hold_frame");
        chk("e_code_next_frame", sig_vec, 1026);
        chk("e_level_popped", fifo_level, 0);

        // Mid-frame reset with buffered entries
        reset_dut(2);
        push(16'h0020);
        run_stable(2048, 1024, "f_frame0");
        run_stable(4096, 1025, "f_frame1");
        push(16'h0040);
        push(16'h0060);
        push(16'h0080);
        while (cyc < 5000) tick();
        chk("f_level_pre", fifo_level, 3);
        chk("f_underrun_pre", underrun, 1);
        chk("f_sigvec_pre", sig_vec, 1025);
        reset_dut(1);
        chk("f_sigvec_post", sig_vec, 1024);
        chk("f_level_post", fifo_level, 0);
        chk("f_underrun_post", underrun, 0);
        chk("f_framestart_post", frame_start, 0);
        chk("f_ready_post", sample_ready, 1);
        fs_bad = 0;
        while (cyc < 2048) begin
            tick();
            if (frame_start !== (cyc == 2048)) fs_bad++;
        end
        chk("f_frame_phase_bad_cycles", fs_bad, 0);
        chk("f_fs_at_2048", frame_start, 1);
        chk("f_sigvec_discarded", sig_vec, 1024);
        chk("f_underrun_again", underrun, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
